// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control bundles,
// the bubble constant and the opcode-to-control table.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       alu_src;
    } ex_ctrl_t;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
    } m_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t ex;
        m_ctrl_t  m;
        wb_ctrl_t wb;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Control bundle for a legal opcode; unknown opcodes decode to a bubble
    function automatic ctrl_t ctrl_for_op(input logic [5:0] op);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (op)
            OP_RTYPE: c = '{ex: 4'b1100, m: 3'b000, wb: 2'b10};
            OP_LW:    c = '{ex: 4'b0001, m: 3'b010, wb: 2'b11};
            OP_SW:    c = '{ex: 4'b0001, m: 3'b001, wb: 2'b00};
            OP_BEQ,
            OP_BNE:   c = '{ex: 4'b0010, m: 3'b100, wb: 2'b00};
            OP_ADDI:  c = '{ex: 4'b0001, m: 3'b000, wb: 2'b10};
            default:  c = CTRL_BUBBLE;
        endcase
        return c;
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Two-read, one-write register file. R0 reads as zero and ignores writes;
// a read of the register being written this cycle returns the write data.
module id_regfile #(
    parameter  int XLEN        = 32,
    parameter  int NREG        = 32,
    parameter  int RF_INIT_IDX = 1,
    localparam int RA_W        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RA_W-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RA_W-1:0] raddr_1,
    output logic [XLEN-1:0] rdata_1,
    input  logic [RA_W-1:0] raddr_2,
    output logic [XLEN-1:0] rdata_2
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_en;

    assign wr_en = we && (waddr != '0);

    // Storage update; reset loads either the index pattern or zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (RF_INIT_IDX != 0) ? XLEN'(i) : '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports with R0 forcing and write-through bypass
    always_comb begin
        rdata_1 = regs[raddr_1];
        rdata_2 = regs[raddr_2];
        if (wr_en && (waddr == raddr_1)) rdata_1 = wdata;
        if (wr_en && (waddr == raddr_2)) rdata_2 = wdata;
        if (raddr_1 == '0) rdata_1 = '0;
        if (raddr_2 == '0) rdata_2 = '0;
    end

endmodule

// File: rtl/id_stage_param.sv
// Parametrised MIPS decode stage: register file, control decode, branch and
// jump resolution, hazard detection and the ID/EX pipeline register.
// Optional illegal-opcode exception reporting is enabled by ID_STAGE_EXC_EN.
module id_stage_param import id_pkg::*; #(
    parameter  int XLEN        = 32,
    parameter  int NREG        = 32,
    parameter  int RF_INIT_IDX = 1,
    localparam int RA_W        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    input  logic            inst_valid_i,
    input  logic            flush_i,
    input  logic            wb_we_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            ex_reg_write_i,
    input  logic            ex_mem_read_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic            mem_mem_read_i,
    input  logic [RA_W-1:0] mem_rd_i,
    output logic            hold_pc_o,
    output logic            hold_if_o,
    output logic            flush_if_o,
    output logic            br_taken_o,
    output logic [XLEN-1:0] pc_branch_o,
    output logic            jump_o,
    output logic [XLEN-1:0] pc_jump_o,
    output logic            id_valid_o,
    output logic [RA_W-1:0] rs_o,
    output logic [RA_W-1:0] rt_o,
    output logic [RA_W-1:0] rd_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] data_1_o,
    output logic [XLEN-1:0] data_2_o,
    output logic [3:0]      ex_o,
    output logic [2:0]      m_o,
    output logic [1:0]      wb_o,
    output logic            exc_o,
    output logic [XLEN-1:0] epc_o
);

    logic [5:0]      opcode;
    logic [RA_W-1:0] rs, rt, rd;
    logic [XLEN-1:0] imm, rdata_1, rdata_2;
    ctrl_t           dec_ctrl;
    logic            legal, is_beq, is_bne, is_branch, is_j, uses_rs, uses_rt;
    logic            ex_hit_rs, ex_hit_rt, load_use, br_hazard, stall, go;

    assign opcode = inst_i[31:26];
    assign rs     = inst_i[21 +: RA_W];
    assign rt     = inst_i[16 +: RA_W];
    assign rd     = inst_i[11 +: RA_W];
    assign imm    = {{(XLEN-16){inst_i[15]}}, inst_i[15:0]};

    assign dec_ctrl  = ctrl_for_op(opcode);
    assign legal     = op_is_legal(opcode);
    assign is_beq    = (opcode == OP_BEQ);
    assign is_bne    = (opcode == OP_BNE);
    assign is_branch = is_beq | is_bne;
    assign is_j      = (opcode == OP_J);
    assign uses_rs   = ~is_j;
    assign uses_rt   = (opcode == OP_RTYPE) | (opcode == OP_SW) | is_branch;

    id_regfile #(
        .XLEN        (XLEN),
        .NREG        (NREG),
        .RF_INIT_IDX (RF_INIT_IDX)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we_i),
        .waddr   (wb_rd_i),
        .wdata   (wb_data_i),
        .raddr_1 (rs),
        .rdata_1 (rdata_1),
        .raddr_2 (rt),
        .rdata_2 (rdata_2)
    );

    // Load-use hazard on any used source, and branch operands not yet in RF
    assign ex_hit_rs = (ex_rd_i != '0) && (ex_rd_i == rs);
    assign ex_hit_rt = (ex_rd_i != '0) && (ex_rd_i == rt);
    assign load_use  = inst_valid_i && ex_mem_read_i &&
                       ((uses_rs && ex_hit_rs) || (uses_rt && ex_hit_rt));
    assign br_hazard = inst_valid_i && is_branch &&
                       ((ex_reg_write_i && (ex_hit_rs || ex_hit_rt)) ||
                        (mem_mem_read_i && (mem_rd_i != '0) &&
                         ((mem_rd_i == rs) || (mem_rd_i == rt))));
    assign stall     = load_use | br_hazard;
    assign go        = inst_valid_i & ~flush_i & ~stall;

    assign hold_pc_o   = stall & ~flush_i;
    assign hold_if_o   = stall & ~flush_i;
    assign br_taken_o  = go & ((is_beq & (rdata_1 == rdata_2)) |
                               (is_bne & (rdata_1 != rdata_2)));
    assign jump_o      = go & is_j;
    assign flush_if_o  = br_taken_o | jump_o;
    assign pc_branch_o = pc_i + (imm << 2);
    assign pc_jump_o   = {pc_i[XLEN-1:28], inst_i[25:0], 2'b00};

    logic            vld_p1;
    ctrl_t           ctrl_p1;
    logic [RA_W-1:0] rs_p1, rt_p1, rd_p1;
    logic [XLEN-1:0] imm_p1, data_1_p1, data_2_p1;

    // ID/EX register: operands always follow ID, control is bubbled unless issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            ctrl_p1   <= CTRL_BUBBLE;
            rs_p1     <= '0;
            rt_p1     <= '0;
            rd_p1     <= '0;
            imm_p1    <= '0;
            data_1_p1 <= '0;
            data_2_p1 <= '0;
        end else begin
            rs_p1     <= rs;
            rt_p1     <= rt;
            rd_p1     <= rd;
            imm_p1    <= imm;
            data_1_p1 <= rdata_1;
            data_2_p1 <= rdata_2;
            if (go && legal) begin
                vld_p1  <= 1'b1;
                ctrl_p1 <= dec_ctrl;
            end else begin
                vld_p1  <= 1'b0;
                ctrl_p1 <= CTRL_BUBBLE;
            end
        end
    end

    assign id_valid_o = vld_p1;
    assign ex_o       = ctrl_p1.ex;
    assign m_o        = ctrl_p1.m;
    assign wb_o       = ctrl_p1.wb;
    assign rs_o       = rs_p1;
    assign rt_o       = rt_p1;
    assign rd_o       = rd_p1;
    assign imm_o      = imm_p1;
    assign data_1_o   = data_1_p1;
    assign data_2_o   = data_2_p1;

`ifdef ID_STAGE_EXC_EN
    logic            exc_p1;
    logic [XLEN-1:0] epc_p1;

    // One-cycle exception pulse carrying the address of the faulting instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_p1 <= 1'b0;
            epc_p1 <= '0;
        end else begin
            exc_p1 <= go & ~legal;
            epc_p1 <= (go & ~legal) ? (pc_i - XLEN'(4)) : '0;
        end
    end

    assign exc_o = exc_p1;
    assign epc_o = epc_p1;
`else
    assign exc_o = 1'b0;
    assign epc_o = '0;
`endif

endmodule

// File: tb/tb_id_stage_param.sv
// Self-checking bench for id_stage_param with randomized stimulus and a
// behavioural model of register contents and decode rules.
module tb_id_stage_param;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RA_W = 5;
`ifdef ID_STAGE_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_i;
    logic [31:0]     inst_i;
    logic            inst_valid_i, flush_i, wb_we_i;
    logic [RA_W-1:0] wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            ex_reg_write_i, ex_mem_read_i, mem_mem_read_i;
    logic [RA_W-1:0] ex_rd_i, mem_rd_i;
    logic            hold_pc_o, hold_if_o, flush_if_o, br_taken_o, jump_o;
    logic [XLEN-1:0] pc_branch_o, pc_jump_o;
    logic            id_valid_o;
    logic [RA_W-1:0] rs_o, rt_o, rd_o;
    logic [XLEN-1:0] imm_o, data_1_o, data_2_o;
    logic [3:0]      ex_o;
    logic [2:0]      m_o;
    logic [1:0]      wb_o;
    logic            exc_o;
    logic [XLEN-1:0] epc_o;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] model_rf [NREG];

    id_stage_param #(.XLEN(XLEN), .NREG(NREG), .RF_INIT_IDX(1)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
        .inst_valid_i(inst_valid_i), .flush_i(flush_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_rd_i(ex_rd_i), .mem_mem_read_i(mem_mem_read_i), .mem_rd_i(mem_rd_i),
        .hold_pc_o(hold_pc_o), .hold_if_o(hold_if_o), .flush_if_o(flush_if_o),
        .br_taken_o(br_taken_o), .pc_branch_o(pc_branch_o), .jump_o(jump_o),
        .pc_jump_o(pc_jump_o), .id_valid_o(id_valid_o), .rs_o(rs_o), .rt_o(rt_o),
        .rd_o(rd_o), .imm_o(imm_o), .data_1_o(data_1_o), .data_2_o(data_2_o),
        .ex_o(ex_o), .m_o(m_o), .wb_o(wb_o), .exc_o(exc_o), .epc_o(epc_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {ex, m, wb} for each opcode, straight from the decode table
    function automatic logic [8:0] exp_ctrl(input logic [5:0] op);
        case (op)
            6'b000000: return 9'b1100_000_10;
            6'b100011: return 9'b0001_010_11;
            6'b101011: return 9'b0001_001_00;
            6'b000100,
            6'b000101: return 9'b0010_100_00;
            6'b001000: return 9'b0001_000_10;
            default:   return 9'b0;
        endcase
    endfunction

    function automatic bit op_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
    endfunction

    // Architectural read as seen during the current cycle
    function automatic logic [XLEN-1:0] exp_read(input int idx);
        if (idx == 0) return '0;
        if (wb_we_i && (int'(wb_rd_i) == idx)) return wb_data_i;
        return model_rf[idx];
    endfunction

    function automatic logic [31:0] mk_inst(input logic [5:0] op, input int rs,
                                            input int rt, input logic [15:0] low);
        logic [4:0] a, b;
        a = 5'(rs);
        b = 5'(rt);
        return {op, a, b, low};
    endfunction

    task automatic drive_idle();
        inst_valid_i = 1'b0; flush_i = 1'b0; inst_i = 32'h0; pc_i = '0;
        wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
        ex_reg_write_i = 1'b0; ex_mem_read_i = 1'b0; ex_rd_i = '0;
        mem_mem_read_i = 1'b0; mem_rd_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (wb_we_i && (wb_rd_i != 0)) model_rf[wb_rd_i] = wb_data_i;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        for (int i = 0; i < NREG; i++) model_rf[i] = XLEN'(i);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid_o); end
        checks++; if ({ex_o, m_o, wb_o} !== 9'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0", {ex_o, m_o, wb_o}); end
        checks++; if ({data_1_o, data_2_o, imm_o} !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", {data_1_o, data_2_o, imm_o}); end
        checks++; if ({exc_o, epc_o} !== '0) begin errors++; $display("FAIL reset_exc got=%h exp=0", {exc_o, epc_o}); end
        checks++; if ({hold_pc_o, hold_if_o, flush_if_o} !== 3'b0) begin errors++; $display("FAIL reset_hold got=%b exp=000", {hold_pc_o, hold_if_o, flush_if_o}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rtype();
        drive_idle();
        inst_valid_i = 1'b1;
        inst_i = mk_inst(6'h00, 1, 2, {5'd3, 11'h020});
        #1;
        checks++; if (hold_pc_o !== 1'b0) begin errors++; $display("FAIL add_hold got=%b exp=0", hold_pc_o); end
        tick();
        checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", id_valid_o); end
        checks++; if (data_1_o !== 32'd1 || data_2_o !== 32'd2) begin errors++; $display("FAIL add_data got=%h/%h exp=1/2", data_1_o, data_2_o); end
        checks++; if (rd_o !== 5'd3) begin errors++; $display("FAIL add_rd got=%0d exp=3", rd_o); end
        checks++; if (ex_o !== 4'b1100 || wb_o !== 2'b10 || m_o !== 3'b000) begin errors++; $display("FAIL add_ctrl got=%b exp=110000010", {ex_o, m_o, wb_o}); end
        drive_idle();
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] e1, e2;
        drive_idle();
        inst_valid_i = 1'b1;
        inst_i = mk_inst(6'h00, 1, 0, {5'd5, 11'h020});
        wb_we_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'hAA;
        #1;
        e1 = exp_read(1);
        tick();
        checks++; if (data_1_o !== e1 || e1 !== 32'hAA) begin errors++; $display("FAIL bypass_rs got=%h exp=%h", data_1_o, 32'hAA); end
        inst_i = mk_inst(6'h00, 0, 1, {5'd6, 11'h020});
        wb_rd_i = 5'd0; wb_data_i = 32'h55;
        #1;
        e2 = exp_read(1);
        tick();
        checks++; if (data_1_o !== 32'h0) begin errors++; $display("FAIL r0_read got=%h exp=0", data_1_o); end
        checks++; if (data_2_o !== e2) begin errors++; $display("FAIL r1_held got=%h exp=%h", data_2_o, e2); end
        drive_idle();
        inst_valid_i = 1'b1;
        inst_i = mk_inst(6'h00, 0, 0, 16'h0);
        tick();
        checks++; if (data_1_o !== 32'h0) begin errors++; $display("FAIL r0_after_write got=%h exp=0", data_1_o); end
        drive_idle();
    endtask

    task automatic test_load_use();
        drive_idle();
        inst_valid_i = 1'b1; ex_mem_read_i = 1'b1; ex_rd_i = 5'd4;
        inst_i = mk_inst(6'h00, 4, 7, {5'd8, 11'h020});
        #1;
        checks++; if (hold_pc_o !== 1'b1 || hold_if_o !== 1'b1) begin errors++; $display("FAIL lu_hold got=%b%b exp=11", hold_pc_o, hold_if_o); end
        tick();
        checks++; if (id_valid_o !== 1'b0 || {ex_o, m_o, wb_o} !== 9'b0) begin errors++; $display("FAIL lu_bubble got=%b/%b exp=0/0", id_valid_o, {ex_o, m_o, wb_o}); end
        // addi does not read rt, so a matching rt must not stall
        inst_i = mk_inst(6'h08, 2, 4, 16'h0010);
        #1;
        checks++; if (hold_pc_o !== 1'b0) begin errors++; $display("FAIL lu_addi_rt got=%b exp=0", hold_pc_o); end
        tick();
        checks++; if (id_valid_o !== 1'b1 || {ex_o, m_o, wb_o} !== 9'b0001_000_10) begin errors++; $display("FAIL addi_ctrl got=%b/%b exp=1/000100010", id_valid_o, {ex_o, m_o, wb_o}); end
        // A load into R0 never creates a dependency
        ex_rd_i = 5'd0;
        inst_i = mk_inst(6'h00, 0, 0, 16'h0);
        #1;
        checks++; if (hold_pc_o !== 1'b0) begin errors++; $display("FAIL lu_r0 got=%b exp=0", hold_pc_o); end
        drive_idle();
    endtask

    task automatic test_branch_jump();
        logic [XLEN-1:0] pc, exp_t;
        drive_idle();
        wb_we_i = 1'b1; wb_rd_i = 5'd2; wb_data_i = model_rf[1];
        tick();
        drive_idle();
        inst_valid_i = 1'b1; pc_i = 32'h100;
        inst_i = mk_inst(6'h04, 1, 2, 16'hFFFF);
        #1;
        checks++; if (br_taken_o !== 1'b1 || flush_if_o !== 1'b1) begin errors++; $display("FAIL beq_taken got=%b%b exp=11", br_taken_o, flush_if_o); end
        checks++; if (pc_branch_o !== 32'hFC) begin errors++; $display("FAIL beq_target got=%h exp=fc", pc_branch_o); end
        ex_reg_write_i = 1'b1; ex_rd_i = 5'd1;
        #1;
        checks++; if (br_taken_o !== 1'b0 || hold_pc_o !== 1'b1 || flush_if_o !== 1'b0) begin errors++; $display("FAIL beq_stall got=%b%b%b exp=010", br_taken_o, hold_pc_o, flush_if_o); end
        tick();
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL beq_bubble got=%b exp=0", id_valid_o); end
        ex_reg_write_i = 1'b0; mem_mem_read_i = 1'b1; mem_rd_i = 5'd2;
        #1;
        checks++; if (hold_pc_o !== 1'b1 || br_taken_o !== 1'b0) begin errors++; $display("FAIL beq_mem_stall got=%b%b exp=10", hold_pc_o, br_taken_o); end
        mem_mem_read_i = 1'b0;
        inst_i = mk_inst(6'h05, 1, 3, 16'h0004);
        #1;
        checks++; if (br_taken_o !== 1'b1) begin errors++; $display("FAIL bne_taken got=%b exp=1", br_taken_o); end
        tick();
        checks++; if (id_valid_o !== 1'b1 || {ex_o, m_o, wb_o} !== 9'b0010_100_00) begin errors++; $display("FAIL bne_ctrl got=%b/%b exp=1/001010000", id_valid_o, {ex_o, m_o, wb_o}); end
        pc = 32'h1000_0104; pc_i = pc;
        inst_i = {6'h02, 26'h0ABCDEF};
        exp_t = (pc & 32'hF000_0000) | (32'h0ABCDEF * 4);
        #1;
        checks++; if (jump_o !== 1'b1 || flush_if_o !== 1'b1 || pc_jump_o !== exp_t) begin errors++; $display("FAIL jump got=%b%b/%h exp=11/%h", jump_o, flush_if_o, pc_jump_o, exp_t); end
        tick();
        checks++; if (id_valid_o !== 1'b1 || {ex_o, m_o, wb_o} !== 9'b0) begin errors++; $display("FAIL jump_ctrl got=%b/%b exp=1/0", id_valid_o, {ex_o, m_o, wb_o}); end
        drive_idle();
    endtask

    task automatic test_flush();
        drive_idle();
        inst_valid_i = 1'b1; flush_i = 1'b1; ex_mem_read_i = 1'b1; ex_rd_i = 5'd4;
        inst_i = mk_inst(6'h00, 4, 5, {5'd6, 11'h020});
        #1;
        checks++; if (hold_pc_o !== 1'b0 || hold_if_o !== 1'b0) begin errors++; $display("FAIL flush_hold got=%b%b exp=00", hold_pc_o, hold_if_o); end
        tick();
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", id_valid_o); end
        ex_mem_read_i = 1'b0;
        inst_i = mk_inst(6'h04, 3, 3, 16'h0001);
        #1;
        checks++; if (br_taken_o !== 1'b0 || flush_if_o !== 1'b0) begin errors++; $display("FAIL flush_branch got=%b%b exp=00", br_taken_o, flush_if_o); end
        drive_idle();
    endtask

    task automatic test_illegal();
        drive_idle();
        inst_valid_i = 1'b1; pc_i = 32'h204;
        inst_i = mk_inst(6'h3F, 0, 0, 16'h0);
        tick();
        checks++; if (id_valid_o !== 1'b0 || {ex_o, m_o, wb_o} !== 9'b0) begin errors++; $display("FAIL illegal_bubble got=%b/%b exp=0/0", id_valid_o, {ex_o, m_o, wb_o}); end
        checks++; if (exc_o !== EXC || epc_o !== (EXC ? 32'h200 : 32'h0)) begin errors++; $display("FAIL illegal_exc got=%b/%h exp=%b/%h", exc_o, epc_o, EXC, EXC ? 32'h200 : 32'h0); end
        drive_idle();
        tick();
        checks++; if (exc_o !== 1'b0) begin errors++; $display("FAIL exc_pulse got=%b exp=0", exc_o); end
    endtask

    task automatic test_random(input int n);
        logic [5:0] ops [8];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3F};
        for (int k = 0; k < n; k++) begin
            logic [5:0]  op;
            int          rs, rt;
            logic [15:0] low;
            logic [31:0] r;
            logic [XLEN-1:0] d1, d2, eimm, ebr, ejmp;
            bit u_rs, u_rt, is_br, lu, bh, stl, go, e_vld, e_tk, e_jp;
            op = ops[$urandom_range(0, 7)];
            rs = $urandom_range(0, 7);
            rt = $urandom_range(0, 7);
            r = $urandom; low = r[15:0];
            inst_i = mk_inst(op, rs, rt, low);
            r = $urandom; pc_i = r & 32'hFFFF_FFFC;
            inst_valid_i = ($urandom_range(0, 7) != 0);
            flush_i = ($urandom_range(0, 7) == 0);
            ex_mem_read_i = $urandom_range(0, 1) == 1;
            ex_reg_write_i = $urandom_range(0, 1) == 1;
            mem_mem_read_i = $urandom_range(0, 1) == 1;
            ex_rd_i = 5'($urandom_range(0, 7));
            mem_rd_i = 5'($urandom_range(0, 7));
            wb_we_i = $urandom_range(0, 1) == 1;
            wb_rd_i = 5'($urandom_range(0, 7));
            wb_data_i = $urandom;
            #1;
            d1 = exp_read(rs);
            d2 = exp_read(rt);
            u_rs = (op != 6'h02);
            u_rt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
            is_br = op inside {6'h04, 6'h05};
            lu = inst_valid_i && ex_mem_read_i && ex_rd_i != 0 &&
                 ((u_rs && ex_rd_i == rs) || (u_rt && ex_rd_i == rt));
            bh = inst_valid_i && is_br &&
                 ((ex_reg_write_i && ex_rd_i != 0 && (ex_rd_i == rs || ex_rd_i == rt)) ||
                  (mem_mem_read_i && mem_rd_i != 0 && (mem_rd_i == rs || mem_rd_i == rt)));
            stl = lu || bh;
            go = inst_valid_i && !flush_i && !stl;
            e_tk = go && ((op == 6'h04 && d1 == d2) || (op == 6'h05 && d1 != d2));
            e_jp = go && (op == 6'h02);
            e_vld = go && op_legal(op);
            eimm = XLEN'($signed(low));
            ebr = pc_i + eimm * 4;
            ejmp = (pc_i & 32'hF000_0000) | ({6'b0, inst_i[25:0]} * 4);
            checks++; if (hold_pc_o !== (stl && !flush_i) || hold_if_o !== (stl && !flush_i)) begin errors++; $display("FAIL rnd_hold[%0d] got=%b%b exp=%b", k, hold_pc_o, hold_if_o, stl && !flush_i); end
            checks++; if (br_taken_o !== e_tk || jump_o !== e_jp || flush_if_o !== (e_tk || e_jp)) begin errors++; $display("FAIL rnd_redirect[%0d] got=%b%b%b exp=%b%b%b", k, br_taken_o, jump_o, flush_if_o, e_tk, e_jp, e_tk || e_jp); end
            checks++; if (pc_branch_o !== ebr || pc_jump_o !== ejmp) begin errors++; $display("FAIL rnd_targets[%0d] got=%h/%h exp=%h/%h", k, pc_branch_o, pc_jump_o, ebr, ejmp); end
            tick();
            checks++; if (id_valid_o !== e_vld || {ex_o, m_o, wb_o} !== (e_vld ? exp_ctrl(op) : 9'b0)) begin errors++; $display("FAIL rnd_idex[%0d] got=%b/%b exp=%b/%b", k, id_valid_o, {ex_o, m_o, wb_o}, e_vld, e_vld ? exp_ctrl(op) : 9'b0); end
            checks++; if (exc_o !== (EXC && go && !op_legal(op))) begin errors++; $display("FAIL rnd_exc[%0d] got=%b exp=%b", k, exc_o, EXC && go && !op_legal(op)); end
            if (e_vld) begin
                checks++; if (data_1_o !== d1 || data_2_o !== d2) begin errors++; $display("FAIL rnd_data[%0d] got=%h/%h exp=%h/%h", k, data_1_o, data_2_o, d1, d2); end
                checks++; if (rs_o !== 5'(rs) || rt_o !== 5'(rt) || rd_o !== low[15:11] || imm_o !== eimm) begin errors++; $display("FAIL rnd_fields[%0d] got=%0d/%0d/%0d/%h exp=%0d/%0d/%0d/%h", k, rs_o, rt_o, rd_o, imm_o, rs, rt, low[15:11], eimm); end
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_bypass();
        test_load_use();
        test_branch_jump();
        test_flush();
        test_illegal();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
Parametrised second-generation MIPS decode stage. It contains:
- a register file with R0 hardwired to zero and a write-through bypass;
- an extended control decoder;
- branch and jump resolution in ID;
- a load-use and branch-operand hazard unit;
- a resettable ID/EX pipeline register with valid bit, bubble insertion and external flush.

It sits between the IF/ID register and EX, and is a drop-in successor to the current ID stage.

Parameters:
- XLEN, 32, datapath width (32 or 64). The immediate and PC are XLEN wide.
- NREG, 32, number of architectural registers (8, 16 or 32). Register indices use the low RA_W=$clog2(NREG) bits of each 5-bit instruction field.
- RF_INIT_IDX, 1, when 1, register i resets to i (bring-up aid). When 0, registers reset to 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pc_i  in  XLEN  PC+4 of the instruction in ID
- inst_i  in  32  instruction from IF/ID
- inst_valid_i  in  1  IF/ID slot holds a real instruction
- flush_i  in  1  squash the instruction in ID (from a later stage)
- wb_we_i  in  1  register write enable from WB
- wb_rd_i  in  RA_W  WB destination
- wb_data_i  in  XLEN  WB data
- ex_reg_write_i  in  1  instruction in EX writes a register
- ex_mem_read_i  in  1  instruction in EX is a load
- ex_rd_i  in  RA_W  EX destination
- mem_mem_read_i  in  1  instruction in MEM is a load
- mem_rd_i  in  RA_W  MEM destination
- hold_pc_o  out  1  freeze PC
- hold_if_o  out  1  freeze IF/ID
- flush_if_o  out  1  squash IF/ID (taken branch or jump)
- br_taken_o  out  1  branch taken
- pc_branch_o  out  XLEN  branch target
- jump_o  out  1  j taken
- pc_jump_o  out  XLEN  jump target
- id_valid_o  out  1  ID/EX valid
- rs_o, rt_o, rd_o  out  RA_W  ID/EX register indices
- imm_o  out  XLEN  ID/EX sign-extended immediate
- data_1_o, data_2_o  out  XLEN  ID/EX operands
- ex_o  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- m_o  out  3  {Branch, MemRead, MemWrite}
- wb_o  out  2  {RegWrite, MemtoReg}
- exc_o  out  1  illegal-opcode exception
- epc_o  out  XLEN  exception PC

Behaviour:

Reset (asynchronous):
- All ID/EX outputs, exc_o and epc_o go to 0.
- The register file loads its RF_INIT_IDX pattern.
- Combinational outputs follow their inputs.

Register file:
- Writes on posedge clk when wb_we_i=1 and wb_rd_i!=0. Writes to R0 are ignored and R0 always reads 0.
- Write-through bypass: a same-cycle read of wb_rd_i returns wb_data_i (when wb_rd_i!=0).
- Two combinational read ports.

Decode, by opcode:
- 000000 (R-type): ex=1100, m=000, wb=10.
- 100011 (lw): ex=0001, m=010, wb=11.
- 101011 (sw): ex=0001, m=001, wb=00.
- 000100 (beq) and 000101 (bne): ex=0010, m=100, wb=00.
- 001000 (addi): ex=0001, m=000, wb=10.
- 000010 (j): all control fields 0, jump.
- Any other opcode is illegal.
- No X values are driven.

Immediate and targets:
- imm is sign-extended inst[15:0] to XLEN.
- pc_branch_o = pc_i + (imm<<2), truncated to XLEN.
- pc_jump_o = {pc_i[XLEN-1:28], inst[25:0], 2'b00}.

Hazard detection (combinational stall):
- Stall when the ID instruction is valid and ex_mem_read_i && ex_rd_i!=0 && ex_rd_i matches any used source.
- Stall when the ID instruction is beq/bne and either:
  - ex_reg_write_i && ex_rd_i!=0 && ex_rd_i matches rs or rt; or
  - mem_mem_read_i && mem_rd_i!=0 && mem_rd_i matches rs or rt.
- Used sources: rs for all instructions except j; rt additionally for R-type, sw, beq and bne.
- A load in EX followed by a dependent branch stalls 2 cycles naturally, as the load advances to MEM.

Stall response:
- hold_pc_o = hold_if_o = 1.
- br_taken_o = jump_o = flush_if_o = 0.
- The next ID/EX update is a bubble: id_valid_o=0 and all control fields 0.

Branch resolution:
- When not stalled, br_taken_o = (data_1==data_2) for beq, (data_1!=data_2) for bne.
- flush_if_o = br_taken_o | jump_o.

ID/EX register (posedge clk), by priority:
1. rst.
2. flush_i or !inst_valid_i: bubble.
3. Stall: bubble.
4. Otherwise capture the decoded instruction with id_valid_o=1.

flush_i also forces hold_*, flush_if_o, br_taken_o and jump_o to 0.

Optional Feature:
- Macro ID_STAGE_EXC_EN.
- Defined: a valid, unflushed illegal opcode registers exc_o=1 and epc_o=pc_i-4 for one cycle, and inserts a bubble.
- Undefined: an illegal opcode becomes a bubble; exc_o and epc_o are tied to 0.

Decomposition:
- Package id_pkg holds:
  - opcode localparams;
  - typedefs ex_ctrl_t, m_ctrl_t and wb_ctrl_t;
  - the constant CTRL_BUBBLE.
- Sub-module id_regfile (parameters XLEN, NREG, RF_INIT_IDX) provides the write-through bypass and R0 handling.
- Decoder and hazard logic stay in id_stage_param.

Test Plan:
1. RF_INIT_IDX=1, add $3,$1,$2, valid -> next cycle id_valid_o=1, data_1_o=1, data_2_o=2, rd_o=3, ex_o=1100, wb_o=10.
2. wb_we_i=1, wb_rd_i=1, wb_data_i=0xAA in the same cycle as an instruction reading rs=1 -> data_1_o=0xAA. Writing 0x55 to R0 -> R0 still reads 0.
3. ex_mem_read_i=1, ex_rd_i=4, ID holds add with rs=4 -> hold_pc_o=hold_if_o=1, next id_valid_o=0, ex_o=m_o=wb_o=0.
4. beq with R1==R2, pc_i=0x100, imm=0xFFFF -> br_taken_o=1, pc_branch_o=0xFC, flush_if_o=1. Same beq with ex_reg_write_i=1, ex_rd_i=1 -> no branch, stall.
5. flush_i=1 during a load-use stall -> hold_pc_o=0, next id_valid_o=0.
6. Opcode 0x3F at pc_i=0x204 -> with ID_STAGE_EXC_EN: exc_o=1, epc_o=0x200. Without: bubble, exc_o=0.
